// File: rtl/compare_pkg.sv
// ============================================================================
// compare_pkg : shared types and helpers for the chunk-serial comparator
// Revision    : 1.0
// ============================================================================
`default_nettype none

package compare_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } cmp_state_t;

  function automatic int chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

`default_nettype wire

// File: rtl/compare_step_timer.sv
// ============================================================================
// compare_step_timer : STEP_CYCLES down-counter, one-cycle tick per slice step
// Revision           : 1.0
// ============================================================================
`default_nettype none

module compare_step_timer #(
  parameter  int STEP_CYCLES = 1,
  localparam int CW          = $clog2(STEP_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  output logic tick
);

  localparam logic [CW-1:0] C_LOAD = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // While inactive the counter sits preloaded, so the first tick lands
  // exactly STEP_CYCLES edges after the start edge.
  always_comb begin
    tick    = active && (count_q == '0);
    count_d = C_LOAD;
    if (active && !tick) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/compare_chunked.sv
// ============================================================================
// compare_chunked : chunk-serial secret comparator, early-exit or constant-time
// Revision        : 1.0
// ============================================================================
`default_nettype none

module compare_chunked
  import compare_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int CHUNK       = 2,
  parameter  int STEP_CYCLES = 1,
  localparam int NUM_CHUNKS  = chunks(WIDTH, CHUNK),
  localparam int IW          = $clog2(NUM_CHUNKS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             restart,
  input  logic             const_time,
  input  logic [WIDTH-1:0] correct_value,
  input  logic [WIDTH-1:0] guessed_value,
  output logic             busy,
  output logic             success,
  output logic             fail,
  output logic [IW-1:0]    match_count
);

  localparam int          NSEL       = 1 << IW;
  localparam logic [IW-1:0] C_LAST_IDX = IW'(NUM_CHUNKS - 1);
  localparam logic [IW-1:0] C_ALL_OK   = IW'(NUM_CHUNKS);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_chk_width
    $error("compare_chunked: WIDTH must be a non-zero multiple of CHUNK");
  end
  if (STEP_CYCLES < 1) begin : g_chk_step
    $error("compare_chunked: STEP_CYCLES must be at least 1");
  end

  cmp_state_t       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] op_c_q, op_c_d;
  logic [WIDTH-1:0] op_g_q, op_g_d;
  logic             ct_q, ct_d;
  logic             miss_q, miss_d;
  logic [IW-1:0]    miss_idx_q, miss_idx_d;
  logic             busy_q, busy_d;
  logic             success_q, success_d;
  logic             fail_q, fail_d;
  logic [IW-1:0]    match_count_q, match_count_d;

  logic             tick;
  logic             slice_ok;
  logic [NSEL-1:0]  slice_eq;

  // Pad the per-slice compare vector to a power of two so the IW-bit index
  // selects it without a range mismatch.
  for (genvar gi = 0; gi < NSEL; gi++) begin : g_slice
    if (gi < NUM_CHUNKS) begin : g_real
      assign slice_eq[gi] = (op_c_q[gi*CHUNK +: CHUNK] == op_g_q[gi*CHUNK +: CHUNK]);
    end else begin : g_pad
      assign slice_eq[gi] = 1'b1;
    end
  end

  assign slice_ok = slice_eq[idx_q];

  compare_step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .active ((state_q == COMPARE) && !restart),
    .tick   (tick)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    op_c_d        = op_c_q;
    op_g_d        = op_g_q;
    ct_d          = ct_q;
    miss_d        = miss_q;
    miss_idx_d    = miss_idx_q;
    busy_d        = busy_q;
    success_d     = success_q;
    fail_d        = fail_q;
    match_count_d = match_count_q;

    case (state_q)
      IDLE: begin
        if (!restart && enable) begin
          state_d    = COMPARE;
          op_c_d     = correct_value;
          op_g_d     = guessed_value;
          ct_d       = const_time;
          idx_d      = '0;
          miss_d     = 1'b0;
          miss_idx_d = '0;
          busy_d     = 1'b1;
        end
      end

      COMPARE: begin
        if (restart) begin
          state_d       = IDLE;
          busy_d        = 1'b0;
          success_d     = 1'b0;
          fail_d        = 1'b0;
          match_count_d = '0;
        end else if (tick) begin
          if (!slice_ok && !ct_q) begin
            state_d       = DONE;
            busy_d        = 1'b0;
            fail_d        = 1'b1;
            match_count_d = idx_q;
          end else if (idx_q == C_LAST_IDX) begin
            state_d = DONE;
            busy_d  = 1'b0;
            if (miss_q) begin
              fail_d        = 1'b1;
              match_count_d = miss_idx_q;
            end else if (!slice_ok) begin
              fail_d        = 1'b1;
              match_count_d = idx_q;
            end else begin
              success_d     = 1'b1;
              match_count_d = C_ALL_OK;
            end
          end else begin
            // Constant-time mode remembers only the first mismatch.
            if (!slice_ok && !miss_q) begin
              miss_d     = 1'b1;
              miss_idx_d = idx_q;
            end
            idx_d = idx_q + IW'(1);
          end
        end
      end

      DONE: begin
        if (!enable || restart) begin
          state_d       = IDLE;
          success_d     = 1'b0;
          fail_d        = 1'b0;
          match_count_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      op_c_q        <= '0;
      op_g_q        <= '0;
      ct_q          <= 1'b0;
      miss_q        <= 1'b0;
      miss_idx_q    <= '0;
      busy_q        <= 1'b0;
      success_q     <= 1'b0;
      fail_q        <= 1'b0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      op_c_q        <= op_c_d;
      op_g_q        <= op_g_d;
      ct_q          <= ct_d;
      miss_q        <= miss_d;
      miss_idx_q    <= miss_idx_d;
      busy_q        <= busy_d;
      success_q     <= success_d;
      fail_q        <= fail_d;
      match_count_q <= match_count_d;
    end
  end

  assign busy        = busy_q;
  assign success     = success_q;
  assign fail        = fail_q;
  assign match_count = match_count_q;

endmodule

`default_nettype wire
